// File: rtl/serial_to_par_rx.sv
// serial_to_par_rx: bit-serial receive deserializer with comma-based byte alignment.
// Hunts for the COMMA byte bit-by-bit. It then confirms alignment over COMMA_COUNT
// consecutive aligned commas and declares the link active. Once active, it emits
// every received byte.
// Ports:
//   clk_32f      - bit clock, one serial bit per rising edge
//   reset        - asynchronous active-high reset
//   data_in_S2P  - serial data, MSB of each byte first
//   data_out     - last byte received while active
//   valid_out    - 1 when data_out holds a non-comma byte
//   byte_strobe  - one-cycle pulse when data_out/valid_out update
//   active       - alignment confirmed, held until reset
//   rx_byte_cnt  - saturating count of valid bytes (only with S2P_BYTE_CNT_EN)
// Optional feature macro: S2P_BYTE_CNT_EN adds rx_byte_cnt.
`timescale 1ns/1ps
module serial_to_par_rx #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned COMMA_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in_S2P,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        byte_strobe,
  output logic        active
`ifdef S2P_BYTE_CNT_EN
  ,
  output logic [15:0] rx_byte_cnt
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BCNT_W = 3;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  // Only the 7 previous bits are kept; the 8th bit of a candidate is the live input.
  logic [6:0]          sr_q, sr_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    comma_cnt_q, comma_cnt_d;
  logic [7:0]          data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic                byte_strobe_q, byte_strobe_d;
  logic                active_q, active_d;
`ifdef S2P_BYTE_CNT_EN
  logic [15:0]         rx_byte_cnt_q, rx_byte_cnt_d;
`endif

  logic [7:0]          cand_c;
  logic                boundary_c;
  logic                is_comma_c;
  logic [CNT_W-1:0]    comma_cnt_inc_c;

  // Candidate byte and byte-boundary decode
  always_comb begin
    cand_c          = {sr_q, data_in_S2P};
    is_comma_c      = (cand_c == COMMA);
    boundary_c      = (bit_cnt_q == BCNT_W'(7));
    comma_cnt_inc_c = comma_cnt_q + CNT_W'(1);
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    sr_d          = cand_c[6:0];
    bit_cnt_d     = bit_cnt_q;
    comma_cnt_d   = comma_cnt_q;
    data_out_d    = data_out_q;
    valid_out_d   = valid_out_q;
    byte_strobe_d = 1'b0;
    active_d      = active_q;
`ifdef S2P_BYTE_CNT_EN
    rx_byte_cnt_d = rx_byte_cnt_q;
`endif

    case (state_q)
      SEARCH: begin
        // Bit-by-bit hunt; a match fixes the byte phase.
        if (is_comma_c) begin
          bit_cnt_d   = '0;
          comma_cnt_d = CNT_W'(1);
          if (COMMA_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = SYNC;
          end
        end
      end

      SYNC: begin
        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        if (boundary_c) begin
          if (is_comma_c) begin
            comma_cnt_d = comma_cnt_inc_c;
            if (comma_cnt_inc_c == CNT_W'(COMMA_COUNT)) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // False match or broken alignment: resume the bitwise hunt.
            comma_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        if (boundary_c) begin
          data_out_d    = cand_c;
          valid_out_d   = !is_comma_c;
          byte_strobe_d = 1'b1;
`ifdef S2P_BYTE_CNT_EN
          if (!is_comma_c && (rx_byte_cnt_q != 16'hFFFF)) begin
            rx_byte_cnt_d = rx_byte_cnt_q + 16'd1;
          end
`endif
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      comma_cnt_q   <= '0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      byte_strobe_q <= 1'b0;
      active_q      <= 1'b0;
`ifdef S2P_BYTE_CNT_EN
      rx_byte_cnt_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      comma_cnt_q   <= comma_cnt_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      byte_strobe_q <= byte_strobe_d;
      active_q      <= active_d;
`ifdef S2P_BYTE_CNT_EN
      rx_byte_cnt_q <= rx_byte_cnt_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign byte_strobe = byte_strobe_q;
  assign active      = active_q;
`ifdef S2P_BYTE_CNT_EN
  assign rx_byte_cnt = rx_byte_cnt_q;
`endif

endmodule

// File: tb/tb_serial_to_par_rx.sv
// tb_serial_to_par_rx: scoreboard bench for serial_to_par_rx.
// The driver shifts directed bytes MSB first and queues each byte expected at the
// output together with the cycle its strobe should appear. The monitor pops on each
// byte_strobe and also checks the held outputs and active on every cycle.
// Define S2P_BYTE_CNT_EN to also cover rx_byte_cnt.
`timescale 1ns/1ps
module tb_serial_to_par_rx;

  localparam logic [7:0] COMMA = 8'hBC;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic        data_in_S2P;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        byte_strobe;
  logic        active;
`ifdef S2P_BYTE_CNT_EN
  logic [15:0] rx_byte_cnt;
`endif

  serial_to_par_rx #(.COMMA(8'hBC), .COMMA_COUNT(4)) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in_S2P (data_in_S2P),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
`ifdef S2P_BYTE_CNT_EN
    ,
    .rx_byte_cnt (rx_byte_cnt)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic [7:0]  d;
    logic        v;
    logic [31:0] c;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;
  exp_t        exp_q[$];
  logic        exp_active = 1'b0;
  logic [7:0]  mon_d = 8'd0;
  logic        mon_v = 1'b0;
`ifdef S2P_BYTE_CNT_EN
  logic [15:0] mon_cnt = 16'd0;
`endif

  always @(posedge clk_32f) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one bit and return just after the edge that samples it.
  task automatic send_bit(input logic b);
    data_in_S2P = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Shift a byte MSB first; while active, queue its expected output.
  task automatic send_byte(input logic [7:0] b);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && exp_active) begin
        e.d = b;
        e.v = (b != COMMA);
        e.c = cyc + 32'd1;
        exp_q.push_back(e);
      end
      send_bit(b[i]);
    end
  endtask

  task automatic do_reset();
    exp_active  = 1'b0;
    reset       = 1'b1;
    data_in_S2P = 1'b0;
    @(posedge clk_32f);
    #1;
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: scoreboard pops on strobe; held values and active checked every cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_32f);
      if (reset) begin
        mon_d = 8'd0;
        mon_v = 1'b0;
`ifdef S2P_BYTE_CNT_EN
        mon_cnt = 16'd0;
`endif
        exp_q.delete();
      end else if (byte_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(byte_strobe), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, e.c);
          mon_d = e.d;
          mon_v = e.v;
`ifdef S2P_BYTE_CNT_EN
          if (e.v && mon_cnt != 16'hFFFF) mon_cnt = mon_cnt + 16'd1;
`endif
        end
      end else if (exp_q.size() != 0 && exp_q[0].c == cyc) begin
        check("missing_strobe", 32'(byte_strobe), 32'd1);
        void'(exp_q.pop_front());
      end
      check("data_out", 32'(data_out), 32'(mon_d));
      check("valid_out", 32'(valid_out), 32'(mon_v));
      check("active", 32'(active), 32'(exp_active));
`ifdef S2P_BYTE_CNT_EN
      check("rx_byte_cnt", 32'(rx_byte_cnt), 32'(mon_cnt));
`endif
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset       = 1'b1;
    data_in_S2P = 1'b0;
    do_reset();

    // Align on 4 commas; no data yet
    repeat (4) send_byte(COMMA);
    check("t1_active", 32'(active), 32'd1);
    check("t1_data_out", 32'(data_out), 32'h00);
    check("t1_valid", 32'(valid_out), 32'd0);
    check("t1_strobe", 32'(byte_strobe), 32'd0);
    exp_active = 1'b1;

    // Data byte then comma
    send_byte(8'hA5);
    check("t2_a5_data", 32'(data_out), 32'hA5);
    check("t2_a5_valid", 32'(valid_out), 32'd1);
    check("t2_a5_strobe", 32'(byte_strobe), 32'd1);
    send_byte(COMMA);
    check("t2_bc_data", 32'(data_out), 32'hBC);
    check("t2_bc_valid", 32'(valid_out), 32'd0);
    check("t2_bc_strobe", 32'(byte_strobe), 32'd1);

    // Broken comma run is rejected, then realigned
    do_reset();
    send_byte(COMMA);
    send_byte(COMMA);
    send_byte(8'h55);
    check("t4_after_55", 32'(active), 32'd0);
    repeat (3) send_byte(COMMA);
    check("t4_three_more", 32'(active), 32'd0);
    send_byte(COMMA);
    check("t4_active", 32'(active), 32'd1);
    exp_active = 1'b1;
    send_byte(8'h66);

    // Misaligned by 3 prefix bits
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (4) send_byte(COMMA);
    check("t3_active", 32'(active), 32'd1);
    exp_active = 1'b1;
    send_byte(8'h3C);
    check("t3_data", 32'(data_out), 32'h3C);
    check("t3_valid", 32'(valid_out), 32'd1);

    // Asynchronous reset midway through 0x7E
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    exp_active = 1'b0;
    reset = 1'b1;
    #2;
    check("t5_data", 32'(data_out), 32'h00);
    check("t5_valid", 32'(valid_out), 32'd0);
    check("t5_active", 32'(active), 32'd0);
    check("t5_strobe", 32'(byte_strobe), 32'd0);
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    repeat (4) send_byte(COMMA);
    check("t5_reacq", 32'(active), 32'd1);
    exp_active = 1'b1;

    // Valid-byte counting
    send_byte(8'h01);
    send_byte(COMMA);
    send_byte(8'h02);
    send_byte(8'h03);
    check("t6_data", 32'(data_out), 32'h03);
`ifdef S2P_BYTE_CNT_EN
    check("t6_byte_cnt", 32'(rx_byte_cnt), 32'd3);
`endif
    send_byte(COMMA);
    repeat (3) @(posedge clk_32f);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_par_rx.md
Name: serial_to_par_rx

Overview:
- Receive-side deserializer fed bit-serially by the parallel-to-serial transmit stage, one bit per clk_32f, MSB first.
- Idle bytes on the link are the comma 0xBC.
- Acquires byte alignment by hunting for the comma and confirms it over COMMA_COUNT consecutive commas, then declares the link active.
- Once active, emits each received byte with a valid flag; commas are reported as not valid.

Parameters:
COMMA, 8'hBC, idle/alignment byte inserted by the transmitter when its valid is low.
COMMA_COUNT, 4, consecutive aligned commas required to go active (legal range 1..15).

Ports:
clk_32f  input  1  bit clock, one serial bit per rising edge.
reset  input  1  asynchronous, active-high reset; clears all state immediately.
data_in_S2P  input  1  serial data, MSB of each byte first.
data_out  output  8  last byte received while active.
valid_out  output  1  1 when data_out holds a non-comma byte.
byte_strobe  output  1  one-cycle pulse when data_out/valid_out update.
active  output  1  alignment confirmed; stays 1 until reset.

Behaviour:
- Reset values (asynchronous): data_out=0, valid_out=0, byte_strobe=0, active=0.
- Internal reset values: shift register sr=0, bit_cnt=0, comma_cnt=0, state=SEARCH.
- Every edge: sr <= {sr[6:0], data_in_S2P}.
- Candidate byte: cand = {sr[6:0], data_in_S2P}, the 8 most recent bits including the current one.
- bit_cnt is 3 bits and wraps 7->0. A byte boundary is an edge with bit_cnt==7.

SEARCH:
- Evaluate cand every edge, ignoring bit_cnt.
- cand==COMMA -> bit_cnt<=0, comma_cnt<=1, go to SYNC. If COMMA_COUNT==1, go directly to ACTIVE with active<=1.
- Otherwise stay in SEARCH.

SYNC:
- Increment bit_cnt each edge.
- At a boundary with cand==COMMA: comma_cnt<=comma_cnt+1.
  - If the new count equals COMMA_COUNT: active<=1, go to ACTIVE.
- At a boundary with cand!=COMMA: comma_cnt<=0, go to SEARCH. The hunt restarts bit-by-bit on the next edge.
- No outputs change in SYNC.

ACTIVE:
- Increment bit_cnt each edge.
- At each boundary: data_out<=cand, valid_out<=(cand!=COMMA), byte_strobe<=1.
- byte_strobe is 0 on all other edges.
- Latency: outputs update on the same edge that samples the byte's 8th bit and are visible the next cycle. They are held for 8 cycles.
- No loss-of-sync exit; only reset leaves ACTIVE.

Boundary conditions:
- A false comma match in SEARCH (0xBC straddling data bytes) is rejected by the SYNC confirmation.
- Reset asserted mid-byte clears everything asynchronously.
- After reset deasserts, the first edge samples into sr; the hunt restarts from scratch.
- Commas received while active set valid_out=0 but still update data_out to 0xBC and pulse byte_strobe.

Optional Feature:
S2P_BYTE_CNT_EN
- Defined: adds output rx_byte_cnt [15:0], reset 0 asynchronously.
  - Increments on every ACTIVE boundary where valid_out is set to 1.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
1. Reset pulse, then 4 aligned 0xBC bytes (32 bits) -> active=1 the cycle after the 32nd bit is sampled; valid_out=0, data_out=0, no byte_strobe yet.
2. After (1), send 0xA5 then 0xBC:
   - 8 cycles after the A5 MSB: data_out=0xA5, valid_out=1, one byte_strobe pulse.
   - 8 cycles later: data_out=0xBC, valid_out=0, byte_strobe pulse.
3. Prefix bits 1,0,1 (misalignment by 3), then 4×0xBC, then 0x3C -> active=1 after the 4th comma; data_out=0x3C, valid_out=1.
4. 2×0xBC, 0x55, then 4×0xBC -> active stays 0 through the 0x55; active=1 only after the 4 later commas (6 commas total sent).
5. In ACTIVE, assert reset at bit 4 of byte 0x7E -> data_out=0, valid_out=0, active=0, byte_strobe=0 before the next clk_32f edge; re-acquire with 4×0xBC.
6. With S2P_BYTE_CNT_EN: after alignment send 0x01, 0xBC, 0x02, 0x03 -> rx_byte_cnt=3. Without the macro, the bench compiles without the port.
